// File: rtl/mux_nw_reg_if.sv
// rtl/mux_nw_reg_if.sv - select/data bundle for mux_nw_reg; y_par exists only with MUX_NW_REG_PARITY_EN
interface mux_nw_reg_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 3
);
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]        sel;
    logic                    sel_valid;
    logic                    scan_en;
    logic                    hold;
    logic [WIDTH-1:0]        y;
    logic                    y_valid;
    logic [SEL_W-1:0]        cur_sel;
    logic                    sel_err;
`ifdef MUX_NW_REG_PARITY_EN
    logic                    y_par;

    modport master (
        output in_bus, sel, sel_valid, scan_en, hold,
        input  y, y_valid, cur_sel, sel_err, y_par
    );

    modport slave (
        input  in_bus, sel, sel_valid, scan_en, hold,
        output y, y_valid, cur_sel, sel_err, y_par
    );
`else
    modport master (
        output in_bus, sel, sel_valid, scan_en, hold,
        input  y, y_valid, cur_sel, sel_err
    );

    modport slave (
        input  in_bus, sel, sel_valid, scan_en, hold,
        output y, y_valid, cur_sel, sel_err
    );
`endif
endinterface

// File: rtl/mux_nw_reg.sv
// rtl/mux_nw_reg.sv - registered N-way word selector with scan, hold and range check; optional y_par via MUX_NW_REG_PARITY_EN
module mux_nw_reg #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 3
) (
    input  logic           clk,
    input  logic           reset,
    mux_nw_reg_if.slave    bus
);
    // One extra bit so NUM_IN == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0]   NUM_IN_EXT = (SEL_W+1)'(NUM_IN);
    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(NUM_IN - 1);

    logic [SEL_W-1:0] sel_q;
    logic             loaded;
    logic [WIDTH-1:0] y_q;
    logic             y_valid_q;
    logic             sel_err_q;
    logic [WIDTH-1:0] word_sel;
    logic             sel_in_range;

    // Pick the word addressed by the current select register (pre-update value).
    always_comb begin
        word_sel = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel_q == SEL_W'(k)) begin
                word_sel = bus.in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_in_range = ({1'b0, bus.sel} < NUM_IN_EXT);

    // Select register, data register and error pulse; hold freezes everything but sel_err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q     <= '0;
            loaded    <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else if (bus.hold) begin
            sel_err_q <= 1'b0;
        end else begin
            y_q       <= word_sel;
            y_valid_q <= loaded;
            if (bus.scan_en) begin
                sel_q     <= (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
                loaded    <= 1'b1;
                sel_err_q <= 1'b0;
            end else if (bus.sel_valid) begin
                if (sel_in_range) begin
                    sel_q     <= bus.sel;
                    loaded    <= 1'b1;
                    sel_err_q <= 1'b0;
                end else begin
                    sel_err_q <= 1'b1;
                end
            end else begin
                sel_err_q <= 1'b0;
            end
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.cur_sel = sel_q;
    assign bus.sel_err = sel_err_q;

`ifdef MUX_NW_REG_PARITY_EN
    logic y_par_q;

    // Parity captured on the same edge as y so the two never disagree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_par_q <= 1'b0;
        end else if (!bus.hold) begin
            y_par_q <= ^word_sel;
        end
    end

    assign bus.y_par = y_par_q;
`endif
endmodule
